// File: rtl/hack_clock_gen.sv
// hack_clock_gen: programmable hack_clk generator with edge strobes,
// glitch-free divisor reload, run/stop and single-step control.
module hack_clock_gen #(
    parameter int CNT_WIDTH    = 6,
    parameter int DEFAULT_HALF = 30,
    parameter int CYCLE_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CNT_WIDTH-1:0]   half_period,
    input  logic                   load,
    input  logic                   run,
    input  logic                   step_req,
    output logic                   hack_clk,
    output logic                   rise_strobe,
    output logic                   fall_strobe,
    output logic                   busy,
    output logic [CYCLE_WIDTH-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        STOPPING
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nx;
    logic [CNT_WIDTH-1:0] active_half;
    logic [CNT_WIDTH-1:0] pending_half;
    logic                 pending_valid;
    logic                 halt_low;
    logic                 toggle;
    logic                 apply_pending;

    // dropping run while low leaves at once without finishing the phase
    assign halt_low = (state == RUN) && !run && !hack_clk;
    assign toggle   = (state != IDLE) && !halt_low
                      && (cnt == active_half);
    assign apply_pending = pending_valid
                           && (toggle || state == IDLE);
    assign busy = (state == STEP) || (state == STOPPING);

    // next-state and phase counter
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (run)
                    state_nx = RUN;
                else if (step_req)
                    state_nx = STEP;
            end
            RUN: begin
                if (halt_low) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = toggle ? '0 : cnt + CNT_WIDTH'(1);
                    if (!run)
                        state_nx = toggle ? IDLE : STOPPING;
                end
            end
            STOPPING: begin
                cnt_nx = toggle ? '0 : cnt + CNT_WIDTH'(1);
                if (toggle)
                    state_nx = IDLE;
            end
            STEP: begin
                cnt_nx = toggle ? '0 : cnt + CNT_WIDTH'(1);
                if (toggle && hack_clk)
                    state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // state and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // generated clock, edge strobes and rise counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hack_clk    <= 1'b0;
            rise_strobe <= 1'b0;
            fall_strobe <= 1'b0;
            cycle_count <= '0;
        end else begin
            rise_strobe <= toggle && !hack_clk;
            fall_strobe <= toggle && hack_clk;
            if (toggle)
                hack_clk <= !hack_clk;
            if (toggle && !hack_clk)
                cycle_count <= cycle_count + CYCLE_WIDTH'(1);
        end
    end

    // divisor only changes at phase boundaries or while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_half   <= CNT_WIDTH'(DEFAULT_HALF);
            pending_half  <= '0;
            pending_valid <= 1'b0;
        end else if (toggle && load) begin
            active_half   <= half_period;
            pending_valid <= 1'b0;
        end else begin
            if (apply_pending)
                active_half <= pending_half;
            if (load) begin
                pending_half  <= half_period;
                pending_valid <= 1'b1;
            end else if (apply_pending) begin
                pending_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hack_clock_gen.sv
// tb_hack_clock_gen: vector table, directed corner cases and random
// stimulus against a phase-length reference model.
module tb_hack_clock_gen;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_STOP = 3;

    logic        clk;
    logic        reset;
    logic [5:0]  half_period;
    logic        load;
    logic        run;
    logic        step_req;
    logic        hack_clk;
    logic        rise_strobe;
    logic        fall_strobe;
    logic        busy;
    logic [31:0] cycle_count;
    logic        w4_hack;
    logic        w4_rise;
    logic        w4_fall;
    logic        w4_busy;
    logic [3:0]  w4_count;

    int checks = 0;
    int errors = 0;

    int          m_mode;
    int          m_left;
    int          m_active;
    int          m_pend;
    bit          m_pval;
    bit          m_hi;
    bit          m_rise;
    bit          m_fall;
    int unsigned m_count;

    typedef struct {
        bit       run;
        bit       step;
        bit       ld;
        bit [5:0] hp;
        bit       hk;
        bit       rs;
        bit       fs;
        bit       bz;
        int       cnt;
    } vec_t;

    vec_t tbl[15];

    hack_clock_gen u_dut (
        .clk         (clk),
        .reset       (reset),
        .half_period (half_period),
        .load        (load),
        .run         (run),
        .step_req    (step_req),
        .hack_clk    (hack_clk),
        .rise_strobe (rise_strobe),
        .fall_strobe (fall_strobe),
        .busy        (busy),
        .cycle_count (cycle_count)
    );

    hack_clock_gen #(.CYCLE_WIDTH(4)) u_w4 (
        .clk         (clk),
        .reset       (reset),
        .half_period (half_period),
        .load        (load),
        .run         (run),
        .step_req    (step_req),
        .hack_clk    (w4_hack),
        .rise_strobe (w4_rise),
        .fall_strobe (w4_fall),
        .busy        (w4_busy),
        .cycle_count (w4_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string name, logic [63:0] act,
                       logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_left   = 0;
        m_active = 30;
        m_pend   = 0;
        m_pval   = 0;
        m_hi     = 0;
        m_rise   = 0;
        m_fall   = 0;
        m_count  = 0;
    endtask

    // one system-clock edge: phases last (H+1) edges, H fixed at
    // the start of each phase
    task automatic model_edge();
        bit tog;
        bit was_hi;
        tog    = 0;
        was_hi = m_hi;
        m_rise = 0;
        m_fall = 0;
        if (m_mode == M_IDLE) begin
            if (m_pval) begin
                m_active = m_pend;
                m_pval   = 0;
            end
            if (load) begin
                m_pend = int'(half_period);
                m_pval = 1;
            end
            if (run) begin
                m_mode = M_RUN;
                m_left = m_active + 1;
            end else if (step_req) begin
                m_mode = M_STEP;
                m_left = m_active + 1;
            end
        end else if (m_mode == M_RUN && !run && !m_hi) begin
            m_mode = M_IDLE;
            if (load) begin
                m_pend = int'(half_period);
                m_pval = 1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                tog    = 1;
                m_hi   = !m_hi;
                m_rise = m_hi;
                m_fall = !m_hi;
                if (m_hi)
                    m_count++;
                if (load) begin
                    m_active = int'(half_period);
                    m_pval   = 0;
                end else if (m_pval) begin
                    m_active = m_pend;
                    m_pval   = 0;
                end
                m_left = m_active + 1;
            end else if (load) begin
                m_pend = int'(half_period);
                m_pval = 1;
            end
            if (m_mode == M_RUN && !run)
                m_mode = tog ? M_IDLE : M_STOP;
            else if (m_mode == M_STOP && tog)
                m_mode = M_IDLE;
            else if (m_mode == M_STEP && tog && was_hi)
                m_mode = M_IDLE;
        end
    endtask

    task automatic tick();
        bit mb;
        @(posedge clk);
        model_edge();
        #1;
        mb = (m_mode == M_STEP) || (m_mode == M_STOP);
        chk("model_outs",
            {hack_clk, rise_strobe, fall_strobe, busy},
            {m_hi, m_rise, m_fall, mb});
        chk("model_count", cycle_count, m_count);
        chk("w4_count", w4_count, m_count % 16);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        run         = 1'b0;
        step_req    = 1'b0;
        load        = 1'b0;
        half_period = '0;
        #2;
        model_reset();
        chk("rst_hack", hack_clk, 0);
        chk("rst_rise", rise_strobe, 0);
        chk("rst_fall", fall_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", cycle_count, 0);
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_edge(bit only_rise, output int n);
        bit hit;
        n   = 0;
        hit = 0;
        while (!hit && n < 400) begin
            tick();
            n++;
            hit = rise_strobe || (!only_rise && fall_strobe);
        end
        chk("edge_timeout", hit, 1);
    endtask

    task automatic load_h(bit [5:0] h);
        load        = 1'b1;
        half_period = h;
        tick();
        load = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int hi_cnt;
        int falls;
        bit exp_hi;

        tbl[0]  = '{0, 0, 1, 6'd1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 6'd0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 6'd0, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 1, 0, 6'd0, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 6'd0, 1, 1, 0, 1, 1};
        tbl[5]  = '{0, 0, 0, 6'd0, 1, 0, 0, 1, 1};
        tbl[6]  = '{0, 0, 0, 6'd0, 0, 0, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 6'd0, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 1, 0, 6'd0, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 0, 0, 6'd0, 0, 0, 0, 0, 1};
        tbl[10] = '{1, 0, 0, 6'd0, 1, 1, 0, 0, 2};
        tbl[11] = '{1, 0, 0, 6'd0, 1, 0, 0, 0, 2};
        tbl[12] = '{1, 0, 0, 6'd0, 0, 0, 1, 0, 2};
        tbl[13] = '{0, 0, 0, 6'd0, 0, 0, 0, 0, 2};
        tbl[14] = '{0, 0, 0, 6'd0, 0, 0, 0, 0, 2};

        do_reset();

        // step with H=1, then run+step together
        foreach (tbl[i]) begin
            run         = tbl[i].run;
            step_req    = tbl[i].step;
            load        = tbl[i].ld;
            half_period = tbl[i].hp;
            tick();
            chk($sformatf("tbl%0d_outs", i),
                {hack_clk, rise_strobe, fall_strobe, busy},
                {tbl[i].hk, tbl[i].rs, tbl[i].fs, tbl[i].bz});
            chk($sformatf("tbl%0d_cnt", i),
                cycle_count, tbl[i].cnt);
        end
        run = 1'b0;
        step_req = 1'b0;
        load = 1'b0;

        // free run with default divisor
        do_reset();
        run = 1'b1;
        tick();
        wait_edge(1, n);
        chk("free_first_rise", n, 31);
        wait_edge(1, n);
        chk("free_period2", n, 62);
        wait_edge(1, n);
        chk("free_period3", n, 62);
        chk("free_count3", cycle_count, 3);

        // stop while high, H=3
        do_reset();
        load_h(6'd3);
        run = 1'b1;
        tick();
        wait_edge(1, n);
        chk("stop_rise", n, 4);
        hi_cnt = 1;
        tick();
        hi_cnt += int'(hack_clk);
        run = 1'b0;
        tick();
        hi_cnt += int'(hack_clk);
        chk("stop_busy", busy, 1);
        falls = 0;
        n = 0;
        while (hack_clk && n < 20) begin
            tick();
            n++;
            hi_cnt += int'(hack_clk);
            falls  += int'(fall_strobe);
        end
        chk("stop_high_len", hi_cnt, 4);
        chk("stop_falls", falls, 1);
        chk("stop_busy_end", busy, 0);
        tick();
        tick();
        chk("stop_idle", {hack_clk, busy}, 0);

        // divisor change mid-phase, then back-to-back loads
        do_reset();
        load_h(6'd7);
        run = 1'b1;
        tick();
        wait_edge(1, n);
        chk("div_rise", n, 8);
        tick();
        tick();
        load = 1'b1;
        half_period = 6'd2;
        tick();
        load = 1'b0;
        wait_edge(0, n);
        chk("div_cur_phase", n + 3, 8);
        wait_edge(0, n);
        chk("div_new_phase", n, 3);
        load = 1'b1;
        half_period = 6'd5;
        tick();
        half_period = 6'd1;
        tick();
        load = 1'b0;
        wait_edge(0, n);
        chk("b2b_cur_phase", n + 2, 3);
        wait_edge(0, n);
        chk("b2b_phase_a", n, 2);
        wait_edge(0, n);
        chk("b2b_phase_b", n, 2);

        // H=0 toggles every cycle, then 4-bit count wrap
        do_reset();
        load_h(6'd0);
        run = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_hi = (i % 2 == 0);
            chk("h0_hack", hack_clk, exp_hi);
            chk("h0_strobe", {rise_strobe, fall_strobe},
                {exp_hi, !exp_hi});
        end
        chk("h0_count", cycle_count, 10);
        n = 0;
        while (cycle_count != 15 && n < 100) begin
            tick();
            n++;
        end
        chk("w4_allones", w4_count, 4'hf);
        wait_edge(1, n);
        chk("w4_wrap", w4_count, 0);
        chk("w4_main16", cycle_count, 16);

        // async reset mid-high discards pending divisor
        do_reset();
        run = 1'b1;
        tick();
        wait_edge(1, n);
        tick();
        load = 1'b1;
        half_period = 6'd2;
        tick();
        load = 1'b0;
        tick();
        chk("ar_high", hack_clk, 1);
        do_reset();
        run = 1'b1;
        tick();
        wait_edge(1, n);
        chk("ar_default_half", n, 31);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0)
                run = ~run;
            step_req    = ($urandom_range(0, 15) == 0);
            load        = ($urandom_range(0, 15) == 0);
            half_period = 6'($urandom_range(0, 4));
            if ($urandom_range(0, 999) < 3)
                do_reset();
            else
                tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_clock_gen.md
# hack_clock_gen

Programmable clock-enable generator for the Hack CPU domain: derives a slow `hack_clk` square wave plus single-cycle edge strobes from the system clock. The half-period is reprogrammable at runtime, with glitch-free updates at phase boundaries. Run/stop control completes the current cycle before stopping, and a single-step mode lets the debug controller advance the CPU one Hack cycle at a time. `cycle_count` counts Hack cycles for profiling.

## Interface
- `CNT_WIDTH`, 6: width of the phase counter and of `half_period`.
- `DEFAULT_HALF`, 30: value of `active_half` after reset; the half-period is `DEFAULT_HALF+1` clk cycles.
- `CYCLE_WIDTH`, 32: width of `cycle_count`.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; all state and outputs go to their reset values immediately.
- `half_period`  in  CNT_WIDTH  new terminal count H; the half-period is H+1 clk cycles.
- `load`  in  1  one-cycle pulse; captures `half_period`.
- `run`  in  1  level; requests free-running operation.
- `step_req`  in  1  one-cycle pulse; requests exactly one Hack cycle.
- `hack_clk`  out  1  generated clock, registered. Reset: 0.
- `rise_strobe`  out  1  high for one clk cycle, in the same cycle `hack_clk` first reads 1. Reset: 0.
- `fall_strobe`  out  1  high for one clk cycle, in the same cycle `hack_clk` first reads 0. Reset: 0.
- `busy`  out  1  high while state is STEP or STOPPING. Reset: 0.
- `cycle_count`  out  CYCLE_WIDTH  number of rising edges of `hack_clk`; wraps modulo 2^CYCLE_WIDTH. Reset: 0.

## Operation
- **States:** IDLE, RUN, STEP, STOPPING. Reset state is IDLE, with `hack_clk`=0 and counter=0.
- **Counter:**
  - Counts 0..`active_half` only in RUN, STEP and STOPPING.
  - At counter==`active_half` (the toggle edge): counter←0, `hack_clk` inverts, and the matching strobe asserts.
  - In IDLE the counter is held at 0.
- **IDLE transitions:**
  - `run`=1 → RUN; counter←0.
  - `run`=0 and `step_req`=1 → STEP; counter←0.
  - `run` and `step_req` in the same cycle: `run` wins and the step is dropped.
- **RUN:**
  - Toggles continuously.
  - `run`=0 while `hack_clk`=0 → IDLE next edge, counter←0, no strobe.
  - `run`=0 while `hack_clk`=1 → STOPPING.
- **STOPPING:**
  - Continues counting until the falling toggle, then → IDLE.
  - Re-asserting `run` here does not cancel the stop. RUN is re-entered from IDLE on a later cycle.
- **STEP:**
  - The first toggle raises `hack_clk`; the second toggle lowers it and the state → IDLE.
  - `step_req` and `run` are ignored during STEP. If `run` is still high afterwards, RUN is entered from IDLE on the next edge.
- **Divisor update:**
  - `load` writes `half_period` into `pending_half` and sets `pending_valid`.
  - In IDLE, a pending value is applied to `active_half` on the next edge.
  - Otherwise it is applied only at a toggle edge, so no phase is ever truncated.
  - `load` coinciding with a toggle edge applies that `half_period` directly at that edge.
  - A second `load` before application overwrites the pending value. Last write wins.
- **H=0:** `hack_clk` toggles every clk cycle; strobes alternate every cycle.
- **`cycle_count`:** increments on each rising toggle, including rises in STEP. All-ones wraps to 0.
- **Reset mid-operation:** `hack_clk` drops to 0 asynchronously, with no `fall_strobe`. The pending divisor is discarded and `active_half`←`DEFAULT_HALF`.

## Timing
- Edge E0 is the edge that enters RUN or STEP.
- The first rise is registered at edge E0+H+1. Thereafter the design toggles every H+1 edges, giving a full period of 2(H+1) clk cycles and 50% duty.
- A step produces a high pulse of exactly H+1 cycles. `busy` is high from E0 through the edge that returns to IDLE; `busy` is 0 in the cycle `hack_clk` returns to 0.
- Strobes and `hack_clk` change on the same edge; strobes never overlap.
- A divisor update adds 0 latency if loaded at a toggle edge. Otherwise it waits at most H+1 cycles.

## Test plan
- **Free run:** reset with defaults, `run`=1 → first `rise_strobe` 31 cycles after entering RUN, then the period is 62 cycles; `cycle_count`=3 after the third rise.
- **Stop while high:** H=3, `run`=1, drop `run` 2 cycles after a rise → `busy`=1, `hack_clk` stays high 4 cycles total, one `fall_strobe`, then IDLE with `busy`=0.
- **Single step:** H=1, IDLE, pulse `step_req` → `hack_clk` high for exactly 2 cycles, one `rise_strobe` and one `fall_strobe`, `cycle_count` +1. A second `step_req` during the step is ignored.
- **Divisor change:** H=7 running, `load` with 2 mid-phase → the current phase still lasts 8 cycles, later phases last 3. Back-to-back loads of 5 then 1 → 1 applies.
- **Edge cases:**
  - H=0 → `hack_clk` toggles every cycle.
  - `run` and `step_req` together in IDLE → RUN, no step.
  - `cycle_count` preset to all-ones via CYCLE_WIDTH=4 after 15 rises → the 16th rise wraps it to 0.
- **Async reset:** assert `reset` mid-high-phase → `hack_clk`=0 and all outputs at reset values before the next `clk` edge. After release, `active_half`=30.
